ad_sample_buffer: RTL

AD_SAMPLE_BUFFER -- requirements
Module: ad_sample_buffer

---
 rtl/ad_sample_buffer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/ad_sample_buffer.sv
// ad_sample_buffer: 16-word sample FIFO between the ADC capture path and the
// DDR controller. Samples arrive in offset-binary and are stored as
// sign-extended two's-complement words. A burst FSM raises
// fifo_ad_full_flag once BURST_LEN words are available. The flag stays up
// until the consumer has taken exactly BURST_LEN reads.
module ad_sample_buffer #(
  parameter int BURST_LEN = 8,
  parameter int DEPTH     = 16
) (
  input  logic        clk_150_0,
  input  logic        reset_syn,
  input  logic [11:0] ad_data,
  input  logic        ad_valid,
  input  logic        ad_enable,
  output logic        fifo_ad_full_flag,
  input  logic        fifo_ad_rreq,
  output logic [15:0] fifo_ad_r_data,
  output logic [4:0]  level,
  output logic        overflow
);

  localparam logic [4:0] FULL_LVL  = 5'(DEPTH);
  localparam logic [4:0] BURST_LVL = 5'(BURST_LEN);
  localparam logic [3:0] LAST_CNT  = 4'(BURST_LEN - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } burstState_t;

  logic [15:0] mem_q [DEPTH];
  logic [3:0]  wrPtr_q;
  logic [3:0]  rdPtr_q;
  logic [4:0]  level_q;
  logic [4:0]  level_d;
  logic [15:0] rData_q;
  logic        overflow_q;
  logic [3:0]  burstCnt_q;
  burstState_t state_q;

  logic        wrAccept;
  logic        rdAccept;
  logic        wrAttempt;
  logic [15:0] convWord;

  // Flip the offset-binary MSB to get two's complement, then sign-extend.
  assign convWord  = {{5{~ad_data[11]}}, ~ad_data[11], ad_data[10:0]};

  assign wrAttempt = ad_valid & ad_enable;
  assign wrAccept  = wrAttempt & (level_q != FULL_LVL);
  assign rdAccept  = fifo_ad_rreq & (level_q != 5'd0);

  // Net occupancy change: +1 on write only, -1 on read only, 0 otherwise.
  always_comb begin
    level_d = level_q;
    if (wrAccept && !rdAccept) begin
      level_d = level_q + 5'd1;
    end else if (rdAccept && !wrAccept) begin
      level_d = level_q - 5'd1;
    end
  end

  // Sample storage; contents are don't-care after reset so no reset here.
  always_ff @(posedge clk_150_0) begin
    if (wrAccept) begin
      mem_q[wrPtr_q] <= convWord;
    end
  end

  // Pointers, occupancy, registered read data and sticky overflow.
  always_ff @(posedge clk_150_0 or posedge reset_syn) begin
    if (reset_syn) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      level_q    <= '0;
      rData_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      level_q <= level_d;
      if (wrAccept) begin
        wrPtr_q <= wrPtr_q + 4'd1;
      end
      if (rdAccept) begin
        rdPtr_q <= rdPtr_q + 4'd1;
        rData_q <= mem_q[rdPtr_q];
      end
      if (wrAttempt && (level_q == FULL_LVL)) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Burst FSM: arm on a full burst, count consumer reads, disarm on the last.
  always_ff @(posedge clk_150_0 or posedge reset_syn) begin
    if (reset_syn) begin
      state_q    <= IDLE;
      burstCnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (level_q >= BURST_LVL) begin
            state_q    <= ARMED;
            burstCnt_q <= '0;
          end
        end
        ARMED: begin
          if (rdAccept) begin
            if (burstCnt_q == LAST_CNT) begin
              state_q    <= IDLE;
              burstCnt_q <= '0;
            end else begin
              burstCnt_q <= burstCnt_q + 4'd1;
            end
          end
        end
        default: begin
          state_q    <= IDLE;
          burstCnt_q <= '0;
        end
      endcase
    end
  end

  assign fifo_ad_full_flag = (state_q == ARMED);
  assign fifo_ad_r_data    = rData_q;
  assign level             = level_q;
  assign overflow          = overflow_q;

endmodule
